// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing one combinational instruction ROM between CPU fetch
// (requester 0) and the debug/trace reader (requester 1), with programmable wait states.
//
// state  | meaning
// IDLE   | waiting for a request; picks a requester and latches its address
// ACCESS | ROM address held stable while the wait counter runs down
// DONE   | captured word presented, owner's valid pulses for one cycle
module rom_fetch_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 28,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReq0,
  input  logic [ADDR_WIDTH-1:0] iAddress0,
  output logic                  oValid0,
  output logic [DATA_WIDTH-1:0] oData0,
  input  logic                  iReq1,
  input  logic [ADDR_WIDTH-1:0] iAddress1,
  output logic                  oValid1,
  output logic [DATA_WIDTH-1:0] oData1,
  output logic [ADDR_WIDTH-1:0] oRomAddress,
  input  logic [DATA_WIDTH-1:0] iRomInstruction,
  output logic                  oBusy,
  output logic                  oOwner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data0_q, data0_d;
  logic [DATA_WIDTH-1:0]   data1_q, data1_d;
  logic                    owner_q, owner_d;
  logic                    last_q, last_d;
  logic                    valid0_q, valid0_d;
  logic                    valid1_q, valid1_d;
  logic                    sel;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    owner_d  = owner_q;
    last_d   = last_q;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    // Under contention the requester not served last wins.
    sel      = (iReq0 && iReq1) ? ~last_q : iReq1;

    unique case (state_q)
      IDLE: begin
        if (iReq0 || iReq1) begin
          owner_d = sel;
          addr_d  = sel ? iAddress1 : iAddress0;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner_q) begin
            data1_d  = iRomInstruction;
            valid1_d = 1'b1;
          end else begin
            data0_d  = iRomInstruction;
            valid0_d = 1'b1;
          end
          last_d  = owner_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign oValid0     = valid0_q;
  assign oValid1     = valid1_q;
  assign oData0      = data0_q;
  assign oData1      = data1_q;
  assign oRomAddress = addr_q;
  assign oOwner      = owner_q;
  assign oBusy       = (state_q != IDLE);

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter: scoreboard of expected (owner, word) per access,
// one instance with WAIT_STATES=1 and one with WAIT_STATES=3.
module tb_rom_fetch_arbiter;

  typedef struct {
    logic        owner;
    logic [27:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        q1[$];
  exp_t        q3[$];

  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic        v0, v1, busy, owner;
  logic [27:0] d0, d1, rom_instr;
  logic [15:0] rom_addr;

  logic        req0_3 = 1'b0, req1_3 = 1'b0;
  logic [15:0] addr0_3 = '0, addr1_3 = '0;
  logic        v0_3, v1_3, busy_3, owner_3;
  logic [27:0] d0_3, d1_3, rom_instr_3;
  logic [15:0] rom_addr_3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [27:0] rom_val(input logic [15:0] a);
    return {12'h0, a} ^ 28'hA5A5A5A;
  endfunction

  assign rom_instr   = rom_val(rom_addr);
  assign rom_instr_3 = rom_val(rom_addr_3);

  rom_fetch_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(28), .WAIT_STATES(1)) u_dut (
    .Clock(clk), .Reset(rst_n),
    .iReq0(req0), .iAddress0(addr0), .oValid0(v0), .oData0(d0),
    .iReq1(req1), .iAddress1(addr1), .oValid1(v1), .oData1(d1),
    .oRomAddress(rom_addr), .iRomInstruction(rom_instr),
    .oBusy(busy), .oOwner(owner)
  );

  rom_fetch_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(28), .WAIT_STATES(3)) u_dut3 (
    .Clock(clk), .Reset(rst_n),
    .iReq0(req0_3), .iAddress0(addr0_3), .oValid0(v0_3), .oData0(d0_3),
    .iReq1(req1_3), .iAddress1(addr1_3), .oValid1(v1_3), .oData1(d1_3),
    .oRomAddress(rom_addr_3), .iRomInstruction(rom_instr_3),
    .oBusy(busy_3), .oOwner(owner_3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the WAIT_STATES=1 instance pulses a valid; which = requester or -1.
  task automatic wait_valid(input int budget, output int which);
    which = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (v0) begin which = 0; return; end
      if (v1) begin which = 1; return; end
    end
    check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (v0 && v1) check("both_valid", 32'd1, 32'd0);
      else if (v0 || v1) begin
        if (q1.size() == 0) check("unexpected_valid", {31'd0, v1}, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = q1.pop_front();
          check("sb_owner", {31'd0, v1}, {31'd0, e.owner});
          check("sb_data", {4'd0, (v1 ? d1 : d0)}, {4'd0, e.data});
        end
      end
      if (v0_3 || v1_3) begin
        if (q3.size() == 0) check("unexpected_valid3", {31'd0, v1_3}, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = q3.pop_front();
          check("sb3_owner", {31'd0, v1_3}, {31'd0, e.owner});
          check("sb3_data", {4'd0, (v1_3 ? d1_3 : d0_3)}, {4'd0, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int t0;
    int last;

    // Reset values
    step(); step();
    check("rst_valid0", {31'd0, v0}, 32'd0);
    check("rst_valid1", {31'd0, v1}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    check("rst_data0", {4'd0, d0}, 32'd0);
    check("rst_data1", {4'd0, d1}, 32'd0);
    check("rst_romaddr", {16'd0, rom_addr}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single requester 0 access, WAIT_STATES=1
    req0 = 1'b1; addr0 = 16'd4;
    q1.push_back('{1'b0, rom_val(16'd4)});
    t0 = cyc;
    step();
    check("t1_romaddr", {16'd0, rom_addr}, 32'd4);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_owner", {31'd0, owner}, 32'd0);
    check("t1_early_valid", {31'd0, v0}, 32'd0);
    step();
    check("t1_valid0", {31'd0, v0}, 32'd1);
    check("t1_data0", {4'd0, d0}, 32'h0A5A5A5E);
    check("t1_latency", cyc - t0, 32'd2);
    req0 = 1'b0;
    step();
    check("t1_valid_pulse", {31'd0, v0}, 32'd0);
    check("t1_valid1", {31'd0, v1}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_data1_untouched", {4'd0, d1}, 32'd0);

    // Contention from reset: strict alternation 0,1,0,1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req0 = 1'b1; addr0 = 16'd1;
    req1 = 1'b1; addr1 = 16'd5;
    for (int n = 0; n < 4; n++)
      q1.push_back('{n[0], (n[0] ? rom_val(16'd5) : rom_val(16'd1))});
    last = cyc;
    for (int n = 0; n < 4; n++) begin
      wait_valid(8, w);
      check("t2_order", w, n % 2);
      check("t2_gap", cyc - last, (n == 0) ? 32'd2 : 32'd3);
      last = cyc;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("t2_data0", {4'd0, d0}, {4'd0, rom_val(16'd1)});
    check("t2_data1", {4'd0, d1}, {4'd0, rom_val(16'd5)});
    step();

    // Requester 1 alone, back-to-back
    req1 = 1'b1; addr1 = 16'd7;
    for (int n = 0; n < 4; n++) q1.push_back('{1'b1, rom_val(16'd7)});
    last = cyc;
    for (int n = 0; n < 4; n++) begin
      wait_valid(8, w);
      check("t3_owner", w, 32'd1);
      check("t3_gap", cyc - last, (n == 0) ? 32'd2 : 32'd3);
      last = cyc;
      if (n < 3) begin
        step();
        check("t3_idle_gap", {31'd0, busy}, 32'd0);
      end
    end
    req1 = 1'b0;
    step();

    // Asynchronous reset during ACCESS aborts the transaction
    req0 = 1'b1; addr0 = 16'd6;
    step();
    check("t4_in_access", {31'd0, busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t4_data0", {4'd0, d0}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_owner", {31'd0, owner}, 32'd0);
    check("t4_valid0", {31'd0, v0}, 32'd0);
    check("t4_romaddr", {16'd0, rom_addr}, 32'd0);
    req0 = 1'b0;
    step();
    #3 rst_n = 1'b1;
    step(); step();
    check("t4_post_idle", {31'd0, busy}, 32'd0);
    req1 = 1'b1; addr1 = 16'd11;
    q1.push_back('{1'b1, rom_val(16'd11)});
    t0 = cyc;
    wait_valid(8, w);
    check("t4_fresh_owner", w, 32'd1);
    check("t4_fresh_latency", cyc - t0, 32'd2);
    check("t4_data0_kept", {4'd0, d0}, 32'd0);
    req1 = 1'b0;
    step();

    // WAIT_STATES=3, address changed during ACCESS is ignored
    req0_3 = 1'b1; addr0_3 = 16'd2;
    q3.push_back('{1'b0, rom_val(16'd2)});
    t0 = cyc;
    step();
    check("t5_romaddr", {16'd0, rom_addr_3}, 32'd2);
    step();
    addr0_3 = 16'd9;
    w = -1;
    for (int i = 0; i < 10 && w < 0; i++) begin
      step();
      if (v0_3) w = 0;
    end
    check("t5_valid", w, 32'd0);
    check("t5_latency", cyc - t0, 32'd4);
    check("t5_data0", {4'd0, d0_3}, {4'd0, rom_val(16'd2)});
    check("t5_romaddr_held", {16'd0, rom_addr_3}, 32'd2);
    req0_3 = 1'b0;
    step();

    // Request dropped during ACCESS still completes
    req0 = 1'b1; addr0 = 16'd3;
    q1.push_back('{1'b0, rom_val(16'd3)});
    t0 = cyc;
    step();
    req0 = 1'b0;
    wait_valid(8, w);
    check("t6_owner", w, 32'd0);
    check("t6_latency", cyc - t0, 32'd2);
    check("t6_data0", {4'd0, d0}, {4'd0, rom_val(16'd3)});
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_idle", {31'd0, busy}, 32'd0);
    end
    check("t6_romaddr_held", {16'd0, rom_addr}, 32'd3);

    check("sb_drained", q1.size(), 32'd0);
    check("sb3_drained", q3.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
